// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the integer register file and its scoreboard.
// Optional feature macro used by this slice: REGFILE_BYPASS_EN (same-cycle write-back bypass).
package regfile_pkg;

    localparam int DEFAULT_XLEN  = 32;
    localparam int DEFAULT_NREGS = 32;
    localparam int ZERO_IDX      = 0;

    typedef logic [$clog2(DEFAULT_NREGS)-1:0] reg_addr_t;

    // Register 0 is hard-wired when zero_reg is set; everything else is writable.
    function automatic logic addr_writable(input logic [31:0] addr, input logic zero_reg);
        return !(zero_reg && (addr == 32'(ZERO_IDX)));
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/write-back bus of the register file: operand reads, issue handshake,
// write-back port and the debug pending vector.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int XLEN   = DEFAULT_XLEN,
    parameter int NREGS  = DEFAULT_NREGS,
    parameter int RPORTS = 2
) ();
    localparam int AW = $clog2(NREGS);

    logic [RPORTS*AW-1:0]   rd_addr;
    logic [RPORTS-1:0]      rd_use;
    logic [RPORTS*XLEN-1:0] rd_data;
    logic                   issue_valid;
    logic                   issue_wr;
    logic [AW-1:0]          issue_rd;
    logic                   issue_ready;
    logic                   wb_en;
    logic [AW-1:0]          wb_addr;
    logic [XLEN-1:0]        wb_data;
    logic [NREGS-1:0]       pending;

    modport master (
        output rd_addr, rd_use, issue_valid, issue_wr, issue_rd, wb_en, wb_addr, wb_data,
        input  rd_data, issue_ready, pending
    );

    modport slave (
        input  rd_addr, rd_use, issue_valid, issue_wr, issue_rd, wb_en, wb_addr, wb_data,
        output rd_data, issue_ready, pending
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: tracks in-flight destinations and flags RAW/WAW hazards.
// With REGFILE_BYPASS_EN the register being written back this cycle is treated
// as already complete for the hazard check.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = DEFAULT_NREGS,
    parameter int RPORTS   = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                 stage_clk,
    input  logic                 reset_n,
    input  logic [RPORTS*AW-1:0] rd_addr,
    input  logic [RPORTS-1:0]    rd_use,
    input  logic                 issue_valid,
    input  logic                 issue_wr,
    input  logic [AW-1:0]        issue_rd,
    input  logic                 wb_en,
    input  logic [AW-1:0]        wb_addr,
    output logic [NREGS-1:0]     pending,
    output logic                 issue_ready
);
    localparam logic ZR = (ZERO_REG != 0);

    logic [NREGS-1:0] pend_eff;
    logic [NREGS-1:0] pend_nxt;
    logic             hazard;
    logic             accept;

    // Pending view used by the hazard check (write-back may retire early under bypass).
    always_comb begin
        pend_eff = pending;
`ifdef REGFILE_BYPASS_EN
        if (wb_en) pend_eff[wb_addr] = 1'b0;
`endif
    end

    // RAW on every consumed read port, plus WAW on the destination.
    always_comb begin
        hazard = issue_wr & pend_eff[issue_rd];
        for (int p = 0; p < RPORTS; p++) begin
            hazard = hazard | (rd_use[p] & pend_eff[rd_addr[p*AW +: AW]]);
        end
    end

    // issue_valid deliberately stays out of issue_ready to avoid a comb loop upstream.
    assign issue_ready = reset_n & ~hazard;
    assign accept      = issue_valid & issue_ready;

    // Clear on write-back first, then set on accept so a new producer wins.
    always_comb begin
        pend_nxt = pending;
        if (wb_en) pend_nxt[wb_addr] = 1'b0;
        if (accept && issue_wr && addr_writable(32'(issue_rd), ZR)) pend_nxt[issue_rd] = 1'b1;
    end

    // Scoreboard register; reset drops all in-flight producers.
    always_ff @(posedge stage_clk or negedge reset_n) begin
        if (!reset_n) pending <= '0;
        else          pending <= pend_nxt;
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port integer register file with pending-write scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN forwards wb_data to same-cycle reads.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN     = DEFAULT_XLEN,
    parameter int NREGS    = DEFAULT_NREGS,
    parameter int RPORTS   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic         stage_clk,
    input  logic         reset_n,
    regfile_sb_if.slave  bus
);
    localparam int   AW = $clog2(NREGS);
    localparam logic ZR = (ZERO_REG != 0);

    logic [XLEN-1:0] regs [NREGS];
    logic            wb_writable;

    assign wb_writable = bus.wb_en & addr_writable(32'(bus.wb_addr), ZR);

    // Storage: cleared by reset, written on an accepted write-back.
    always_ff @(posedge stage_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_writable) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Combinational read muxes, one per port.
    always_comb begin
        logic [AW-1:0] a;
        a           = '0;
        bus.rd_data = '0;
        for (int p = 0; p < RPORTS; p++) begin
            a = bus.rd_addr[p*AW +: AW];
            if (!addr_writable(32'(a), ZR)) begin
                bus.rd_data[p*XLEN +: XLEN] = '0;
`ifdef REGFILE_BYPASS_EN
            end else if (wb_writable && (a == bus.wb_addr)) begin
                bus.rd_data[p*XLEN +: XLEN] = bus.wb_data;
`endif
            end else begin
                bus.rd_data[p*XLEN +: XLEN] = regs[a];
            end
        end
    end

    reg_scoreboard #(
        .NREGS    (NREGS),
        .RPORTS   (RPORTS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .stage_clk   (stage_clk),
        .reset_n     (reset_n),
        .rd_addr     (bus.rd_addr),
        .rd_use      (bus.rd_use),
        .issue_valid (bus.issue_valid),
        .issue_wr    (bus.issue_wr),
        .issue_rd    (bus.issue_rd),
        .wb_en       (bus.wb_en),
        .wb_addr     (bus.wb_addr),
        .pending     (bus.pending),
        .issue_ready (bus.issue_ready)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb: directed hazard scenarios plus randomized traffic
// compared against an array-based reference model of registers and pending set.
module tb_regfile_sb;
    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int RPORTS = 2;
    localparam int AW     = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic stage_clk = 1'b0;
    logic reset_n   = 1'b0;
    always #5 stage_clk = ~stage_clk;

    regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .RPORTS(RPORTS)) bus ();

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .RPORTS(RPORTS), .ZERO_REG(1)) dut (
        .stage_clk (stage_clk),
        .reset_n   (reset_n),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_x    [NREGS];
    bit          m_pend [NREGS];
    logic [31:0] nx_x   [NREGS];
    bit          nx_pend[NREGS];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int r = 0; r < NREGS; r++) begin
            m_x[r] = '0; m_pend[r] = 1'b0; nx_x[r] = '0; nx_pend[r] = 1'b0;
        end
    endfunction

    // Compare all outputs against the model for the inputs currently driven,
    // and prepare the model state that the next rising edge should produce.
    task automatic model_check();
        bit          eff[NREGS];
        bit          haz;
        bit          exp_ready;
        logic [31:0] pv;
        logic [4:0]  a;
        logic [31:0] e;
        for (int r = 0; r < NREGS; r++)
            eff[r] = m_pend[r] && !(BYP && bus.wb_en && (int'(bus.wb_addr) == r));
        haz = bus.issue_wr && eff[bus.issue_rd];
        for (int p = 0; p < RPORTS; p++)
            if (bus.rd_use[p] && eff[bus.rd_addr[p*AW +: AW]]) haz = 1'b1;
        exp_ready = reset_n && !haz;
        chk("issue_ready", {63'd0, bus.issue_ready}, {63'd0, exp_ready});
        pv = '0;
        for (int r = 0; r < NREGS; r++) pv[r] = m_pend[r];
        chk("pending", {32'd0, bus.pending}, {32'd0, pv});
        for (int p = 0; p < RPORTS; p++) begin
            a = bus.rd_addr[p*AW +: AW];
            if (a == 0)                                      e = 32'd0;
            else if (BYP && bus.wb_en && (a == bus.wb_addr)) e = bus.wb_data;
            else                                             e = m_x[a];
            chk($sformatf("rd_data[%0d] x%0d", p, a), {32'd0, bus.rd_data[p*XLEN +: XLEN]}, {32'd0, e});
        end
        nx_x    = m_x;
        nx_pend = m_pend;
        if (bus.wb_en && bus.wb_addr != 0) nx_x[bus.wb_addr] = bus.wb_data;
        if (bus.wb_en) nx_pend[bus.wb_addr] = 1'b0;
        if (bus.issue_valid && exp_ready && bus.issue_wr && bus.issue_rd != 0) nx_pend[bus.issue_rd] = 1'b1;
    endtask

    task automatic drive(input logic [2*AW-1:0] ra, input logic [1:0] ru, input logic iv,
                         input logic iw, input logic [AW-1:0] ird, input logic we,
                         input logic [AW-1:0] wa, input logic [31:0] wd);
        @(negedge stage_clk);
        bus.rd_addr = ra;  bus.rd_use = ru;
        bus.issue_valid = iv; bus.issue_wr = iw; bus.issue_rd = ird;
        bus.wb_en = we; bus.wb_addr = wa; bus.wb_data = wd;
        #1;
        model_check();
    endtask

    task automatic commit();
        @(posedge stage_clk);
        m_x    = nx_x;
        m_pend = nx_pend;
    endtask

    task automatic idle_cycle();
        drive('0, 2'b00, 1'b0, 1'b0, '0, 1'b0, '0, '0);
        commit();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2*AW-1:0] ra;
        model_reset();
        // Write-back attempted while held in reset must be ignored.
        bus.rd_addr = {5'd0, 5'd5}; bus.rd_use = 2'b00;
        bus.issue_valid = 1'b1; bus.issue_wr = 1'b1; bus.issue_rd = 5'd5;
        bus.wb_en = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEAD;
        @(posedge stage_clk); #2;
        chk("rst_rd_x5", {32'd0, bus.rd_data[31:0]}, 64'd0);
        chk("rst_pending", {32'd0, bus.pending}, 64'd0);
        chk("rst_ready", {63'd0, bus.issue_ready}, 64'd0);
        @(negedge stage_clk);
        bus.wb_en = 1'b0; bus.issue_valid = 1'b0; bus.issue_wr = 1'b0;
        reset_n = 1'b1;
        #1;
        chk("ready_after_rst", {63'd0, bus.issue_ready}, 64'd1);
        idle_cycle();

        // Zero register.
        drive('0, 2'b00, 1'b0, 1'b0, '0, 1'b1, 5'd0, 32'hFFFF_FFFF); commit();
        drive('0, 2'b00, 1'b1, 1'b1, 5'd0, 1'b0, '0, '0);
        chk("x0_read", {32'd0, bus.rd_data[31:0]}, 64'd0);
        commit();
        drive('0, 2'b00, 1'b0, 1'b0, '0, 1'b0, '0, '0);
        chk("x0_not_pending", {63'd0, bus.pending[0]}, 64'd0);
        commit();

        // RAW stall on port 1.
        drive('0, 2'b00, 1'b1, 1'b1, 5'd7, 1'b0, '0, '0); commit();
        ra = {5'd7, 5'd0};
        drive(ra, 2'b10, 1'b1, 1'b0, '0, 1'b0, '0, '0);
        chk("raw_stall", {63'd0, bus.issue_ready}, 64'd0);
        commit();
        drive(ra, 2'b10, 1'b1, 1'b0, '0, 1'b1, 5'd7, 32'h1234);
`ifdef REGFILE_BYPASS_EN
        chk("raw_wb_ready", {63'd0, bus.issue_ready}, 64'd1);
        chk("raw_wb_data", {32'd0, bus.rd_data[63:32]}, 64'h1234);
        commit();
`else
        chk("raw_wb_ready", {63'd0, bus.issue_ready}, 64'd0);
        chk("raw_wb_data", {32'd0, bus.rd_data[63:32]}, 64'd0);
        commit();
        drive(ra, 2'b10, 1'b1, 1'b0, '0, 1'b0, '0, '0);
        chk("raw_late_ready", {63'd0, bus.issue_ready}, 64'd1);
        chk("raw_late_data", {32'd0, bus.rd_data[63:32]}, 64'h1234);
        commit();
`endif

        // WAW, and an unconsumed read of a pending register.
        drive('0, 2'b00, 1'b1, 1'b1, 5'd3, 1'b0, '0, '0); commit();
        drive({5'd0, 5'd3}, 2'b00, 1'b1, 1'b1, 5'd3, 1'b0, '0, '0);
        chk("waw_stall", {63'd0, bus.issue_ready}, 64'd0);
        commit();
        drive({5'd0, 5'd3}, 2'b00, 1'b1, 1'b0, '0, 1'b0, '0, '0);
        chk("unused_read_no_stall", {63'd0, bus.issue_ready}, 64'd1);
        commit();
        drive('0, 2'b00, 1'b0, 1'b0, '0, 1'b1, 5'd3, 32'h33); commit();

`ifdef REGFILE_BYPASS_EN
        // Set wins over clear on the same edge.
        drive('0, 2'b00, 1'b1, 1'b1, 5'd9, 1'b0, '0, '0); commit();
        drive('0, 2'b00, 1'b1, 1'b1, 5'd9, 1'b1, 5'd9, 32'h99);
        chk("set_wins_ready", {63'd0, bus.issue_ready}, 64'd1);
        commit();
        drive('0, 2'b00, 1'b0, 1'b0, '0, 1'b0, '0, '0);
        chk("set_wins_pending", {63'd0, bus.pending[9]}, 64'd1);
        commit();
        drive('0, 2'b00, 1'b0, 1'b0, '0, 1'b1, 5'd9, 32'h999); commit();
`endif

        // Mid-operation asynchronous reset.
        drive('0, 2'b00, 1'b0, 1'b0, '0, 1'b1, 5'd4, 32'h44); commit();
        drive('0, 2'b00, 1'b1, 1'b1, 5'd4, 1'b0, '0, '0); commit();
        drive('0, 2'b00, 1'b1, 1'b1, 5'd8, 1'b0, '0, '0); commit();
        drive({5'd8, 5'd4}, 2'b00, 1'b0, 1'b0, '0, 1'b0, '0, '0);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_pending", {32'd0, bus.pending}, 64'd0);
        chk("midrst_ready", {63'd0, bus.issue_ready}, 64'd0);
        chk("midrst_x4", {32'd0, bus.rd_data[31:0]}, 64'd0);
        chk("midrst_x8", {32'd0, bus.rd_data[63:32]}, 64'd0);
        for (int i = 0; i < NREGS / 2; i++) begin
            @(negedge stage_clk);
            bus.rd_addr = {5'(2*i+1), 5'(2*i)};
            #1;
            chk($sformatf("midrst_rd x%0d", 2*i),   {32'd0, bus.rd_data[31:0]},  64'd0);
            chk($sformatf("midrst_rd x%0d", 2*i+1), {32'd0, bus.rd_data[63:32]}, 64'd0);
        end
        model_reset();
        @(negedge stage_clk);
        reset_n = 1'b1;
        idle_cycle();

        // Randomized traffic over a narrow address range to provoke hazards.
        for (int n = 0; n < 600; n++) begin
            logic [AW-1:0] a0, a1, ird, wa;
            a0  = 5'($urandom_range(0, 9));
            a1  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 9));
            ird = 5'($urandom_range(0, 9));
            wa  = 5'($urandom_range(0, 9));
            drive({a1, a0}, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ird, 1'($urandom_range(0, 2) == 0), wa, $urandom());
            commit();
        end
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
